// File: rtl/xdn_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// xdn_ctrl_pkg
// Shared definitions for the 8-bit bus CPU control sequencer:
//   - opcode constants (OP_NOP .. OP_HLT)
//   - control-word bit indices, plus the inactive and fetch control words
//   - micro-step constants T0..T4
//   - sequencer run/halt state type
// The control word is held active-high internally. Active-low pins are
// produced by inverting the relevant bits when the word is unpacked at the top.
// -----------------------------------------------------------------------------
package xdn_ctrl_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam int T0 = 0;
  localparam int T1 = 1;
  localparam int T2 = 2;
  localparam int T3 = 3;
  localparam int T4 = 4;

  localparam int CW_WIDTH    = 15;
  localparam int CW_PC_OUT   = 0;
  localparam int CW_PC_EN    = 1;
  localparam int CW_JUMP     = 2;
  localparam int CW_MAR_IN   = 3;
  localparam int CW_RAM_IN   = 4;
  localparam int CW_RAM_OUT  = 5;
  localparam int CW_IR_IN    = 6;
  localparam int CW_IR_OUT   = 7;
  localparam int CW_A_IN     = 8;
  localparam int CW_A_OUT    = 9;
  localparam int CW_B_IN     = 10;
  localparam int CW_ALU_OUT  = 11;
  localparam int CW_SUB      = 12;
  localparam int CW_FLAGS_IN = 13;
  localparam int CW_OUT_IN   = 14;

  typedef logic [CW_WIDTH-1:0] ctrl_word_t;

  typedef enum logic {
    SEQ_RUN,
    SEQ_HALTED
  } seq_state_t;

  // One-hot control word with a single strobe asserted.
  function automatic ctrl_word_t cw_bit(input int idx);
    ctrl_word_t w;
    w = '0;
    w[idx] = 1'b1;
    return w;
  endfunction

  localparam ctrl_word_t CW_INACTIVE = '0;
  localparam ctrl_word_t CW_FETCH    = cw_bit(CW_PC_OUT) | cw_bit(CW_MAR_IN);

endpackage

// File: rtl/control_sequencer_if.sv
// -----------------------------------------------------------------------------
// control_sequencer_if
// Bundle between the control sequencer and the CPU datapath.
//   Datapath -> sequencer : i_OPCODE (IR[7:4]), i_ZERO_FLAG, i_CARRY_FLAG
//   Sequencer -> datapath : o_STEP, o_HALT and the control strobes
//                           (o_PC_EN and o_SUB active-high, all *_n active-low)
// Modports: master = sequencer side, slave = datapath side.
// -----------------------------------------------------------------------------
interface control_sequencer_if #(
  parameter int OPCODE_WIDTH = 4,
  parameter int STEP_WIDTH   = 3
);

  logic [OPCODE_WIDTH-1:0] i_OPCODE;
  logic                    i_ZERO_FLAG;
  logic                    i_CARRY_FLAG;
  logic [STEP_WIDTH-1:0]   o_STEP;
  logic                    o_HALT;
  logic                    o_PC_OUT_n;
  logic                    o_PC_EN;
  logic                    o_JUMP_n;
  logic                    o_MAR_IN_n;
  logic                    o_RAM_IN_n;
  logic                    o_RAM_OUT_n;
  logic                    o_IR_IN_n;
  logic                    o_IR_OUT_n;
  logic                    o_A_IN_n;
  logic                    o_A_OUT_n;
  logic                    o_B_IN_n;
  logic                    o_ALU_OUT_n;
  logic                    o_SUB;
  logic                    o_FLAGS_IN_n;
  logic                    o_OUT_IN_n;

  modport master (
    input  i_OPCODE, i_ZERO_FLAG, i_CARRY_FLAG,
    output o_STEP, o_HALT,
    output o_PC_OUT_n, o_PC_EN, o_JUMP_n, o_MAR_IN_n, o_RAM_IN_n,
    output o_RAM_OUT_n, o_IR_IN_n, o_IR_OUT_n, o_A_IN_n, o_A_OUT_n,
    output o_B_IN_n, o_ALU_OUT_n, o_SUB, o_FLAGS_IN_n, o_OUT_IN_n
  );

  modport slave (
    output i_OPCODE, i_ZERO_FLAG, i_CARRY_FLAG,
    input  o_STEP, o_HALT,
    input  o_PC_OUT_n, o_PC_EN, o_JUMP_n, o_MAR_IN_n, o_RAM_IN_n,
    input  o_RAM_OUT_n, o_IR_IN_n, o_IR_OUT_n, o_A_IN_n, o_A_OUT_n,
    input  o_B_IN_n, o_ALU_OUT_n, o_SUB, o_FLAGS_IN_n, o_OUT_IN_n
  );

endinterface

// File: rtl/control_sequencer_rom.sv
// -----------------------------------------------------------------------------
// control_rom
// Combinational microcode decode: {opcode, step, zero flag, carry flag} ->
// active-high control word.
//   opcode     : instruction opcode (IR[7:4])
//   step       : current micro-step
//   zero_flag  : registered ALU zero flag (used by JZ at T2)
//   carry_flag : registered ALU carry flag (used by JC at T2)
//   ctrl_word  : active-high control word (bit indices in xdn_ctrl_pkg)
//   last_step  : this is the opcode's final active step (early-end option)
//   halt_req   : HLT reached T2; the halt latch sets at the next edge
// -----------------------------------------------------------------------------
module control_rom
  import xdn_ctrl_pkg::*;
#(
  parameter int OPCODE_WIDTH = 4,
  parameter int STEP_WIDTH   = 3
) (
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic [STEP_WIDTH-1:0]   step,
  input  logic                    zero_flag,
  input  logic                    carry_flag,
  output ctrl_word_t              ctrl_word,
  output logic                    last_step,
  output logic                    halt_req
);

  logic is_t2;
  logic is_t3;
  logic is_t4;
  logic is_sub;

  assign is_t2  = (step == STEP_WIDTH'(T2));
  assign is_t3  = (step == STEP_WIDTH'(T3));
  assign is_t4  = (step == STEP_WIDTH'(T4));
  assign is_sub = (opcode == OPCODE_WIDTH'(OP_SUB));

  // Fetch is common to every opcode; execute steps depend on the opcode.
  // Unused opcodes fall through to the NOP behaviour. The last_step flag marks
  // where an instruction could end early; HLT never sets it because it stops
  // the sequencer instead.
  always_comb begin
    ctrl_word = CW_INACTIVE;
    last_step = 1'b0;
    halt_req  = 1'b0;
    if (step == STEP_WIDTH'(T0)) begin
      ctrl_word = CW_FETCH;
    end else if (step == STEP_WIDTH'(T1)) begin
      ctrl_word = cw_bit(CW_RAM_OUT) | cw_bit(CW_IR_IN) | cw_bit(CW_PC_EN);
    end else begin
      case (opcode)
        OPCODE_WIDTH'(OP_NOP): begin
          last_step = is_t2;
        end
        OPCODE_WIDTH'(OP_LDA): begin
          if (is_t2) begin
            ctrl_word = cw_bit(CW_IR_OUT) | cw_bit(CW_MAR_IN);
          end else if (is_t3) begin
            ctrl_word = cw_bit(CW_RAM_OUT) | cw_bit(CW_A_IN);
            last_step = 1'b1;
          end
        end
        OPCODE_WIDTH'(OP_ADD), OPCODE_WIDTH'(OP_SUB): begin
          if (is_t2) begin
            ctrl_word = cw_bit(CW_IR_OUT) | cw_bit(CW_MAR_IN);
          end else if (is_t3) begin
            ctrl_word = cw_bit(CW_RAM_OUT) | cw_bit(CW_B_IN);
            ctrl_word[CW_SUB] = is_sub;
          end else if (is_t4) begin
            ctrl_word = cw_bit(CW_ALU_OUT) | cw_bit(CW_A_IN) | cw_bit(CW_FLAGS_IN);
            ctrl_word[CW_SUB] = is_sub;
            last_step = 1'b1;
          end
        end
        OPCODE_WIDTH'(OP_STA): begin
          if (is_t2) begin
            ctrl_word = cw_bit(CW_IR_OUT) | cw_bit(CW_MAR_IN);
          end else if (is_t3) begin
            ctrl_word = cw_bit(CW_A_OUT) | cw_bit(CW_RAM_IN);
            last_step = 1'b1;
          end
        end
        OPCODE_WIDTH'(OP_LDI): begin
          if (is_t2) begin
            ctrl_word = cw_bit(CW_IR_OUT) | cw_bit(CW_A_IN);
            last_step = 1'b1;
          end
        end
        OPCODE_WIDTH'(OP_JMP): begin
          if (is_t2) begin
            ctrl_word = cw_bit(CW_IR_OUT) | cw_bit(CW_JUMP);
            last_step = 1'b1;
          end
        end
        OPCODE_WIDTH'(OP_JC): begin
          if (is_t2) begin
            if (carry_flag) begin
              ctrl_word = cw_bit(CW_IR_OUT) | cw_bit(CW_JUMP);
            end
            last_step = 1'b1;
          end
        end
        OPCODE_WIDTH'(OP_JZ): begin
          if (is_t2) begin
            if (zero_flag) begin
              ctrl_word = cw_bit(CW_IR_OUT) | cw_bit(CW_JUMP);
            end
            last_step = 1'b1;
          end
        end
        OPCODE_WIDTH'(OP_OUT): begin
          if (is_t2) begin
            ctrl_word = cw_bit(CW_A_OUT) | cw_bit(CW_OUT_IN);
            last_step = 1'b1;
          end
        end
        OPCODE_WIDTH'(OP_HLT): begin
          halt_req = is_t2;
        end
        default: begin
          last_step = is_t2;
        end
      endcase
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
// Microcoded control unit for the 8-bit bus CPU. Holds the micro-step counter
// and the halt latch, decodes the control word through control_rom and
// unpacks it onto the datapath strobes.
//   i_CLOCK   : system clock, step counter advances on posedge
//   i_CLEAR_n : asynchronous active-low reset (step 0, halt cleared)
//   bus       : control_sequencer_if.master (opcode/flags in; step, halt and
//               control strobes out)
// Build option: define SEQ_EARLY_END_EN to return the step counter to 0 right
// after an opcode's last active step instead of always running STEP_COUNT
// steps per instruction.
// -----------------------------------------------------------------------------
module control_sequencer
  import xdn_ctrl_pkg::*;
#(
  parameter int OPCODE_WIDTH = 4,
  parameter int STEP_COUNT   = 5,
  parameter int STEP_WIDTH   = 3
) (
  input  logic                i_CLOCK,
  input  logic                i_CLEAR_n,
  control_sequencer_if.master bus
);

`ifdef SEQ_EARLY_END_EN
  localparam bit EARLY_END = 1'b1;
`else
  localparam bit EARLY_END = 1'b0;
`endif

  seq_state_t            state_q;
  seq_state_t            state_d;
  logic [STEP_WIDTH-1:0] step_q;
  logic [STEP_WIDTH-1:0] step_d;
  ctrl_word_t            rom_word;
  ctrl_word_t            cw;
  logic                  rom_last;
  logic                  rom_halt;

  control_rom #(
    .OPCODE_WIDTH (OPCODE_WIDTH),
    .STEP_WIDTH   (STEP_WIDTH)
  ) u_rom (
    .opcode     (bus.i_OPCODE),
    .step       (step_q),
    .zero_flag  (bus.i_ZERO_FLAG),
    .carry_flag (bus.i_CARRY_FLAG),
    .ctrl_word  (rom_word),
    .last_step  (rom_last),
    .halt_req   (rom_halt)
  );

  // State and step registers. Reset drops straight back to T0 so an
  // interrupted instruction leaves nothing behind.
  always_ff @(posedge i_CLOCK or negedge i_CLEAR_n) begin
    if (!i_CLEAR_n) begin
      state_q <= SEQ_RUN;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  // Next state/step. HLT at T2 still advances the step once, so the counter
  // freezes on the step after T2; once halted only reset moves anything.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    if (state_q == SEQ_RUN) begin
      if (rom_halt) begin
        state_d = SEQ_HALTED;
      end
      if ((step_q == STEP_WIDTH'(STEP_COUNT - 1)) || (EARLY_END && rom_last)) begin
        step_d = '0;
      end else begin
        step_d = step_q + STEP_WIDTH'(1);
      end
    end
  end

  // While halted the datapath must see a fully idle word, whatever the
  // opcode and frozen step would otherwise decode to.
  always_comb begin
    cw = rom_word;
    if (state_q == SEQ_HALTED) begin
      cw = CW_INACTIVE;
    end
  end

  assign bus.o_STEP       = step_q;
  assign bus.o_HALT       = (state_q == SEQ_HALTED);
  assign bus.o_PC_OUT_n   = ~cw[CW_PC_OUT];
  assign bus.o_PC_EN      =  cw[CW_PC_EN];
  assign bus.o_JUMP_n     = ~cw[CW_JUMP];
  assign bus.o_MAR_IN_n   = ~cw[CW_MAR_IN];
  assign bus.o_RAM_IN_n   = ~cw[CW_RAM_IN];
  assign bus.o_RAM_OUT_n  = ~cw[CW_RAM_OUT];
  assign bus.o_IR_IN_n    = ~cw[CW_IR_IN];
  assign bus.o_IR_OUT_n   = ~cw[CW_IR_OUT];
  assign bus.o_A_IN_n     = ~cw[CW_A_IN];
  assign bus.o_A_OUT_n    = ~cw[CW_A_OUT];
  assign bus.o_B_IN_n     = ~cw[CW_B_IN];
  assign bus.o_ALU_OUT_n  = ~cw[CW_ALU_OUT];
  assign bus.o_SUB        =  cw[CW_SUB];
  assign bus.o_FLAGS_IN_n = ~cw[CW_FLAGS_IN];
  assign bus.o_OUT_IN_n   = ~cw[CW_OUT_IN];

endmodule

// File: tb/tb_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_control_sequencer
// Directed self-checking bench for control_sequencer. Observed outputs are
// packed into a 15-bit pin vector (MSB first):
//   PC_OUT_n PC_EN JUMP_n MAR_IN_n RAM_IN_n RAM_OUT_n IR_IN_n IR_OUT_n
//   A_IN_n A_OUT_n B_IN_n ALU_OUT_n SUB FLAGS_IN_n OUT_IN_n
// Expected vectors are the idle pin pattern with the asserted strobes flipped.
// Honours SEQ_EARLY_END_EN for instruction lengths.
// -----------------------------------------------------------------------------
module tb_control_sequencer;

`ifdef SEQ_EARLY_END_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  localparam logic [14:0] IDLE       = 15'b101111111111011;
  localparam logic [14:0] M_PC_OUT   = 15'h4000;
  localparam logic [14:0] M_PC_EN    = 15'h2000;
  localparam logic [14:0] M_JUMP     = 15'h1000;
  localparam logic [14:0] M_MAR_IN   = 15'h0800;
  localparam logic [14:0] M_RAM_IN   = 15'h0400;
  localparam logic [14:0] M_RAM_OUT  = 15'h0200;
  localparam logic [14:0] M_IR_IN    = 15'h0100;
  localparam logic [14:0] M_IR_OUT   = 15'h0080;
  localparam logic [14:0] M_A_IN     = 15'h0040;
  localparam logic [14:0] M_A_OUT    = 15'h0020;
  localparam logic [14:0] M_B_IN     = 15'h0010;
  localparam logic [14:0] M_ALU_OUT  = 15'h0008;
  localparam logic [14:0] M_SUB      = 15'h0004;
  localparam logic [14:0] M_FLAGS_IN = 15'h0002;
  localparam logic [14:0] M_OUT_IN   = 15'h0001;

  localparam logic [14:0] W_T0      = IDLE ^ M_PC_OUT ^ M_MAR_IN;
  localparam logic [14:0] W_T1      = IDLE ^ M_RAM_OUT ^ M_IR_IN ^ M_PC_EN;
  localparam logic [14:0] W_IR_MAR  = IDLE ^ M_IR_OUT ^ M_MAR_IN;
  localparam logic [14:0] W_IR_JUMP = IDLE ^ M_IR_OUT ^ M_JUMP;
  localparam logic [14:0] W_RAM_A   = IDLE ^ M_RAM_OUT ^ M_A_IN;

  localparam logic [2:0] LEN3 = EARLY ? 3'd3 : 3'd5;
  localparam logic [2:0] LEN4 = EARLY ? 3'd4 : 3'd5;

  typedef struct packed {
    logic [3:0]       op;
    logic             zf;
    logic             cf;
    logic [2:0]       len;
    logic [4:0][14:0] w;
  } vec_t;

  logic i_CLOCK = 1'b0;
  logic i_CLEAR_n;
  int   checks   = 0;
  int   failures = 0;

  control_sequencer_if #(.OPCODE_WIDTH(4), .STEP_WIDTH(3)) bus ();

  control_sequencer #(
    .OPCODE_WIDTH (4),
    .STEP_COUNT   (5),
    .STEP_WIDTH   (3)
  ) dut (
    .i_CLOCK   (i_CLOCK),
    .i_CLEAR_n (i_CLEAR_n),
    .bus       (bus)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 i_CLOCK = ~i_CLOCK;

  function automatic logic [14:0] outs();
    return {bus.o_PC_OUT_n, bus.o_PC_EN, bus.o_JUMP_n, bus.o_MAR_IN_n,
            bus.o_RAM_IN_n, bus.o_RAM_OUT_n, bus.o_IR_IN_n, bus.o_IR_OUT_n,
            bus.o_A_IN_n, bus.o_A_OUT_n, bus.o_B_IN_n, bus.o_ALU_OUT_n,
            bus.o_SUB, bus.o_FLAGS_IN_n, bus.o_OUT_IN_n};
  endfunction

  task automatic tick();
    @(posedge i_CLOCK);
    #1;
  endtask

  // Reset state, then an asynchronous reset in the middle of LDA T3.
  task automatic test_reset();
    i_CLEAR_n = 1'b0;
    bus.i_OPCODE = 4'h1;
    bus.i_ZERO_FLAG = 1'b0;
    bus.i_CARRY_FLAG = 1'b0;
    #2;
    checks++;
    if (bus.o_STEP !== 3'd0) begin
      failures++;
      $display("[TB] FAIL reset_step got %0d want 0", bus.o_STEP);
    end
    checks++;
    if (bus.o_HALT !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_halt got %b want 0", bus.o_HALT);
    end
    checks++;
    if (outs() !== W_T0) begin
      failures++;
      $display("[TB] FAIL reset_word got %b want %b", outs(), W_T0);
    end
    i_CLEAR_n = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if (bus.o_STEP !== 3'd3 || outs() !== W_RAM_A) begin
      failures++;
      $display("[TB] FAIL lda_t3 got step %0d word %b want step 3 word %b",
               bus.o_STEP, outs(), W_RAM_A);
    end
    #2;
    i_CLEAR_n = 1'b0;
    #1;
    checks++;
    if (bus.o_STEP !== 3'd0 || bus.o_PC_OUT_n !== 1'b0 || bus.o_MAR_IN_n !== 1'b0 ||
        bus.o_A_IN_n !== 1'b1 || bus.o_HALT !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midreset got step %0d pc_out_n %b mar_in_n %b a_in_n %b halt %b want 0 0 0 1 0",
               bus.o_STEP, bus.o_PC_OUT_n, bus.o_MAR_IN_n, bus.o_A_IN_n, bus.o_HALT);
    end
    checks++;
    if (outs() !== W_T0) begin
      failures++;
      $display("[TB] FAIL midreset_word got %b want %b", outs(), W_T0);
    end
    i_CLEAR_n = 1'b1;
  endtask

  // ADD and SUB with both flags set, which must not matter.
  task automatic test_arith();
    vec_t v [2];
    v[0] = '{op: 4'h2, zf: 1'b1, cf: 1'b1, len: 3'd5,
             w: {IDLE ^ M_ALU_OUT ^ M_A_IN ^ M_FLAGS_IN, IDLE ^ M_RAM_OUT ^ M_B_IN,
                 W_IR_MAR, W_T1, W_T0}};
    v[1] = '{op: 4'h3, zf: 1'b1, cf: 1'b1, len: 3'd5,
             w: {IDLE ^ M_ALU_OUT ^ M_A_IN ^ M_FLAGS_IN ^ M_SUB,
                 IDLE ^ M_RAM_OUT ^ M_B_IN ^ M_SUB, W_IR_MAR, W_T1, W_T0}};
    for (int i = 0; i < 2; i++) begin
      bus.i_OPCODE = v[i].op;
      bus.i_ZERO_FLAG = v[i].zf;
      bus.i_CARRY_FLAG = v[i].cf;
      for (int s = 0; s < int'(v[i].len); s++) begin
        checks++;
        if (bus.o_STEP !== 3'(s)) begin
          failures++;
          $display("[TB] FAIL arith op%h step got %0d want %0d", v[i].op, bus.o_STEP, s);
        end
        checks++;
        if (outs() !== v[i].w[s]) begin
          failures++;
          $display("[TB] FAIL arith op%h T%0d word got %b want %b", v[i].op, s, outs(), v[i].w[s]);
        end
        tick();
      end
      checks++;
      if (bus.o_STEP !== 3'd0) begin
        failures++;
        $display("[TB] FAIL arith op%h wrap got %0d want 0", v[i].op, bus.o_STEP);
      end
    end
  endtask

  // JC and JZ, untaken with the other flag set, then taken.
  task automatic test_cond_jumps();
    vec_t v [4];
    v[0] = '{op: 4'h7, zf: 1'b1, cf: 1'b0, len: LEN3, w: {IDLE, IDLE, IDLE, W_T1, W_T0}};
    v[1] = '{op: 4'h7, zf: 1'b0, cf: 1'b1, len: LEN3, w: {IDLE, IDLE, W_IR_JUMP, W_T1, W_T0}};
    v[2] = '{op: 4'h8, zf: 1'b0, cf: 1'b1, len: LEN3, w: {IDLE, IDLE, IDLE, W_T1, W_T0}};
    v[3] = '{op: 4'h8, zf: 1'b1, cf: 1'b0, len: LEN3, w: {IDLE, IDLE, W_IR_JUMP, W_T1, W_T0}};
    for (int i = 0; i < 4; i++) begin
      bus.i_OPCODE = v[i].op;
      bus.i_ZERO_FLAG = v[i].zf;
      bus.i_CARRY_FLAG = v[i].cf;
      for (int s = 0; s < int'(v[i].len); s++) begin
        checks++;
        if (bus.o_STEP !== 3'(s)) begin
          failures++;
          $display("[TB] FAIL jump%0d step got %0d want %0d", i, bus.o_STEP, s);
        end
        checks++;
        if (outs() !== v[i].w[s]) begin
          failures++;
          $display("[TB] FAIL jump%0d T%0d word got %b want %b", i, s, outs(), v[i].w[s]);
        end
        tick();
      end
      checks++;
      if (bus.o_STEP !== 3'd0) begin
        failures++;
        $display("[TB] FAIL jump%0d wrap got %0d want 0", i, bus.o_STEP);
      end
    end
  endtask

  // Remaining opcodes, including an unused one that behaves as NOP.
  task automatic test_misc_ops();
    vec_t v [7];
    v[0] = '{op: 4'h1, zf: 1'b0, cf: 1'b0, len: LEN4, w: {IDLE, W_RAM_A, W_IR_MAR, W_T1, W_T0}};
    v[1] = '{op: 4'h4, zf: 1'b0, cf: 1'b0, len: LEN4,
             w: {IDLE, IDLE ^ M_A_OUT ^ M_RAM_IN, W_IR_MAR, W_T1, W_T0}};
    v[2] = '{op: 4'h5, zf: 1'b0, cf: 1'b0, len: LEN3,
             w: {IDLE, IDLE, IDLE ^ M_IR_OUT ^ M_A_IN, W_T1, W_T0}};
    v[3] = '{op: 4'h6, zf: 1'b0, cf: 1'b0, len: LEN3, w: {IDLE, IDLE, W_IR_JUMP, W_T1, W_T0}};
    v[4] = '{op: 4'hE, zf: 1'b0, cf: 1'b0, len: LEN3,
             w: {IDLE, IDLE, IDLE ^ M_A_OUT ^ M_OUT_IN, W_T1, W_T0}};
    v[5] = '{op: 4'h0, zf: 1'b1, cf: 1'b1, len: LEN3, w: {IDLE, IDLE, IDLE, W_T1, W_T0}};
    v[6] = '{op: 4'hB, zf: 1'b1, cf: 1'b1, len: LEN3, w: {IDLE, IDLE, IDLE, W_T1, W_T0}};
    for (int i = 0; i < 7; i++) begin
      bus.i_OPCODE = v[i].op;
      bus.i_ZERO_FLAG = v[i].zf;
      bus.i_CARRY_FLAG = v[i].cf;
      for (int s = 0; s < int'(v[i].len); s++) begin
        checks++;
        if (bus.o_STEP !== 3'(s)) begin
          failures++;
          $display("[TB] FAIL op%h step got %0d want %0d", v[i].op, bus.o_STEP, s);
        end
        checks++;
        if (outs() !== v[i].w[s]) begin
          failures++;
          $display("[TB] FAIL op%h T%0d word got %b want %b", v[i].op, s, outs(), v[i].w[s]);
        end
        tick();
      end
      checks++;
      if (bus.o_STEP !== 3'd0) begin
        failures++;
        $display("[TB] FAIL op%h wrap got %0d want 0", v[i].op, bus.o_STEP);
      end
    end
  endtask

  // LDI, LDA, ADD back to back: cycles until the step returns to 0.
  task automatic test_back_to_back();
    logic [3:0] ops  [3] = '{4'h5, 4'h1, 4'h2};
    int         lens [3] = '{int'(LEN3), int'(LEN4), 5};
    int         cnt;
    for (int i = 0; i < 3; i++) begin
      bus.i_OPCODE = ops[i];
      cnt = 0;
      do begin
        tick();
        cnt++;
      end while (bus.o_STEP !== 3'd0 && cnt < 10);
      checks++;
      if (cnt != lens[i]) begin
        failures++;
        $display("[TB] FAIL length op%h got %0d cycles want %0d", ops[i], cnt, lens[i]);
      end
    end
  endtask

  // HLT: latch after T2, frozen step and idle word, only reset releases it.
  task automatic test_halt();
    bus.i_OPCODE = 4'hF;
    tick();
    tick();
    checks++;
    if (bus.o_STEP !== 3'd2 || bus.o_HALT !== 1'b0 || outs() !== IDLE) begin
      failures++;
      $display("[TB] FAIL hlt_t2 got step %0d halt %b word %b want 2 0 %b",
               bus.o_STEP, bus.o_HALT, outs(), IDLE);
    end
    tick();
    checks++;
    if (bus.o_HALT !== 1'b1) begin
      failures++;
      $display("[TB] FAIL hlt_latch got %b want 1", bus.o_HALT);
    end
    bus.i_OPCODE = 4'h1;
    bus.i_ZERO_FLAG = 1'b1;
    bus.i_CARRY_FLAG = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      checks++;
      if (bus.o_STEP !== 3'd3 || bus.o_HALT !== 1'b1 || outs() !== IDLE) begin
        failures++;
        $display("[TB] FAIL halted cycle %0d got step %0d halt %b word %b want 3 1 %b",
                 c, bus.o_STEP, bus.o_HALT, outs(), IDLE);
      end
    end
    i_CLEAR_n = 1'b0;
    #2;
    checks++;
    if (bus.o_HALT !== 1'b0 || bus.o_STEP !== 3'd0) begin
      failures++;
      $display("[TB] FAIL unhalt got halt %b step %0d want 0 0", bus.o_HALT, bus.o_STEP);
    end
    i_CLEAR_n = 1'b1;
    #1;
    checks++;
    if (outs() !== W_T0) begin
      failures++;
      $display("[TB] FAIL resume_t0 got %b want %b", outs(), W_T0);
    end
    tick();
    checks++;
    if (bus.o_STEP !== 3'd1 || outs() !== W_T1) begin
      failures++;
      $display("[TB] FAIL resume_t1 got step %0d word %b want 1 %b", bus.o_STEP, outs(), W_T1);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_cond_jumps();
    test_misc_ops();
    test_back_to_back();
    test_halt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Microcoded control unit for the 8-bit bus CPU.
- Runs a step counter through fetch and execute micro-steps and decodes {opcode, step, flags} into the control word for the datapath:
  - PC, MAR, RAM, IR, A/B registers, ALU, flags register, output register.
- Drives the ALU's active-low bus-write, SUB and active-low flag-update strobes.
- Consumes the ALU's registered zero and carry flags for conditional jumps.

Parameters:
- OPCODE_WIDTH, 4, width of the opcode field (IR[7:4]).
- STEP_COUNT, 5, number of micro-steps per instruction (T0..T4); minimum 3.
- STEP_WIDTH, 3, width of the step counter; must satisfy 2**STEP_WIDTH >= STEP_COUNT.

Ports:
- i_CLOCK  in  1  system clock; step counter advances on posedge.
- i_CLEAR_n  in  1  async active-low reset.
- i_OPCODE  in  OPCODE_WIDTH  opcode from the instruction register.
- i_ZERO_FLAG  in  1  ALU zero flag (registered).
- i_CARRY_FLAG  in  1  ALU carry flag (registered).
- o_STEP  out  STEP_WIDTH  current micro-step.
- o_HALT  out  1  halt latch; high = clock-gated stop.
- Active-low outputs, one per line, in order:
  - o_PC_OUT_n  out  1  PC drives bus.
  - o_PC_EN  out  1  PC increment (active-high).
  - o_JUMP_n  out  1  PC loads from bus.
  - o_MAR_IN_n  out  1  MAR loads.
  - o_RAM_IN_n  out  1  RAM write.
  - o_RAM_OUT_n  out  1  RAM drives bus.
  - o_IR_IN_n  out  1  IR loads.
  - o_IR_OUT_n  out  1  IR operand (IR[3:0]) drives bus.
  - o_A_IN_n  out  1  A register loads.
  - o_A_OUT_n  out  1  A register drives bus.
  - o_B_IN_n  out  1  B register loads.
  - o_ALU_OUT_n  out  1  ALU result drives bus.
  - o_SUB  out  1  ALU subtract select (active-high).
  - o_FLAGS_IN_n  out  1  ALU flags update.
  - o_OUT_IN_n  out  1  output register loads.

Behaviour:
- Reset (i_CLEAR_n low, async):
  - step = 0, halt = 0.
  - Every control output takes the T0 fetch word: o_PC_OUT_n = 0, o_MAR_IN_n = 0, all other _n = 1, o_PC_EN = 0, o_SUB = 0.
  - A reset mid-instruction aborts the instruction; no partial state is retained.
- Timing:
  - Step register updates on posedge i_CLOCK.
  - Control word is a pure combinational decode of the registered step, i_OPCODE and flags, so the datapath samples it at the next posedge (one step per cycle).
- Step counting: step increments 0 → STEP_COUNT-1, then wraps to 0.
- Fetch (all opcodes):
  - T0: PC_OUT, MAR_IN.
  - T1: RAM_OUT, IR_IN, PC_EN.
- Execute, T2..T4 (unlisted steps = all inactive):
  - 0x0 NOP: none.
  - 0x1 LDA: T2 IR_OUT, MAR_IN; T3 RAM_OUT, A_IN.
  - 0x2 ADD: T2 IR_OUT, MAR_IN; T3 RAM_OUT, B_IN; T4 ALU_OUT, A_IN, FLAGS_IN.
  - 0x3 SUB: as ADD, with o_SUB=1 in T3 and T4.
  - 0x4 STA: T2 IR_OUT, MAR_IN; T3 A_OUT, RAM_IN.
  - 0x5 LDI: T2 IR_OUT, A_IN.
  - 0x6 JMP: T2 IR_OUT, JUMP.
  - 0x7 JC: T2 IR_OUT, JUMP only if i_CARRY_FLAG=1; else none.
  - 0x8 JZ: T2 IR_OUT, JUMP only if i_ZERO_FLAG=1; else none.
  - 0xE OUT: T2 A_OUT, OUT_IN.
  - 0xF HLT: T2 sets halt at the next posedge.
  - 0x9–0xD: treated as NOP.
- Flags are sampled combinationally at T2. Because the ALU flags register and A_IN load at the same T4 edge, a conditional jump immediately following ADD/SUB sees the updated flags.
- Halt behaviour:
  - Step counter frozen at the step after T2; control word forced all-inactive (o_PC_EN=0, o_SUB=0, all _n=1).
  - Only i_CLEAR_n leaves halt.
- Bus exclusivity invariant: at most one of PC_OUT, RAM_OUT, IR_OUT, A_OUT, ALU_OUT asserted in any step.
- Opcode changes between T0 and T1 are don't-care; the decode is only meaningful from T2 onward (IR loaded at end of T1).

Optional Feature:
- Macro: SEQ_EARLY_END_EN.
- Defined:
  - After an opcode's last active step, the step counter returns to 0 at the next posedge instead of running to STEP_COUNT-1.
  - Resulting lengths: NOP and untaken JC/JZ = 3 cycles; LDI, JMP, taken jumps, OUT = 3; LDA, STA = 4; ADD, SUB = 5.
  - HLT still halts at T2.
- Undefined: every instruction takes exactly STEP_COUNT cycles; trailing steps emit the inactive word.

Decomposition:
- Shared package/include xdn_ctrl_pkg holds:
  - Opcode constants (OP_NOP..OP_HLT).
  - Control-word bit indices and the inactive/fetch control-word constants.
  - Step constants T0..T4.
- Sub-module control_rom: combinational {opcode, step, ZF, CF} → control word plus a "last step" bit (used by SEQ_EARLY_END_EN).
- control_sequencer holds the step counter, halt latch and output unpacking.

Test Plan:
- Reset mid-T3 of LDA: drop i_CLEAR_n → same cycle o_STEP=0, o_PC_OUT_n=0, o_MAR_IN_n=0, o_A_IN_n=1, o_HALT=0.
- ADD (opcode 0x2), flags ignored → T2 IR_OUT_n=0 & MAR_IN_n=0; T3 RAM_OUT_n=0 & B_IN_n=0; T4 ALU_OUT_n=0, A_IN_n=0, FLAGS_IN_n=0, o_SUB=0; then o_STEP=0.
- SUB (0x3) → o_SUB=1 in T3 and T4 only; FLAGS_IN_n=0 only in T4.
- JC with i_CARRY_FLAG=0, then =1 → T2 o_JUMP_n=1 first case; o_JUMP_n=0 and o_IR_OUT_n=0 second case. Repeat for JZ with i_ZERO_FLAG.
- HLT (0xF) → o_HALT=1 after the T2 edge; 20 further clocks: o_STEP constant, all _n=1, o_PC_EN=0; i_CLEAR_n pulse → o_HALT=0, fetch resumes.
- With SEQ_EARLY_END_EN: sequence LDI, LDA, ADD → o_STEP returns to 0 after 3, 4, 5 cycles respectively. Without the macro: 5 cycles each.
